ro_freq_reader: RTL and testbench

RO_FREQ_READER -- requirements
Module: ro_freq_reader

---
 rtl/ro_freq_reader.sv | 169 ++++++++++++++++
 tb/tb_ro_freq_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_reader.sv
// Two-channel ring-oscillator frequency reader: snapshots both RO counters, waits winLen clk
// cycles, snapshots again and reports the differences. Define RO_READ_STABLE_CHECK_EN for the stability check and retry limit.
module ro_freq_reader #(
    parameter int length   = 16,
    parameter int winLen   = 1024,
    parameter int maxRetry = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [length-1:0] RO0Cnt,
    input  logic [length-1:0] RO1Cnt,
    output logic              busy,
    output logic [length-1:0] RO0Freq,
    output logic [length-1:0] RO1Freq,
    output logic              freqValid,
    input  logic              freqReady,
    output logic              err
);

    if (length < 2 || length > 31 || winLen < 2 || winLen > (2 ** length) - 1 ||
        maxRetry < 1 || maxRetry > 255) begin : g_bad_params
        $error("ro_freq_reader: parameter out of range");
    end

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CAP0 = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CAP1 = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic [length-1:0] WIN_LOAD = length'(winLen - 1);

    logic [2:0]        state_q, state_d;
    logic [length-1:0] a0_q, a1_q;
    logic [length-1:0] win_q, win_d;
    logic [length-1:0] start0_q, start0_d, start1_q, start1_d;
    logic [length-1:0] freq0_q, freq0_d, freq1_q, freq1_d;
    logic              take;

`ifdef RO_READ_STABLE_CHECK_EN
    localparam logic [7:0] RETRY_LIMIT = 8'(maxRetry);

    logic [length-1:0] b0_q, b1_q;
    logic [7:0]        retry_q, retry_d, retry_inc;
    logic              err_q, err_d;

    // The counters are asynchronous: a value is trusted only when two successive samples agree.
    assign take      = (a0_q == b0_q) && (a1_q == b1_q);
    assign retry_inc = retry_q + 8'd1;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q    <= '0;
            b1_q    <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            b0_q    <= a0_q;
            b1_q    <= a1_q;
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end
`else
    assign take = 1'b1;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            a0_q     <= '0;
            a1_q     <= '0;
            state_q  <= S_IDLE;
            win_q    <= '0;
            start0_q <= '0;
            start1_q <= '0;
            freq0_q  <= '0;
            freq1_q  <= '0;
        end else begin
            a0_q     <= RO0Cnt;
            a1_q     <= RO1Cnt;
            state_q  <= state_d;
            win_q    <= win_d;
            start0_q <= start0_d;
            start1_q <= start1_d;
            freq0_q  <= freq0_d;
            freq1_q  <= freq1_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal is defaulted to hold first, so no path can infer a latch.
        state_d  = state_q;
        win_d    = win_q;
        start0_d = start0_q;
        start1_d = start1_q;
        freq0_d  = freq0_q;
        freq1_d  = freq1_q;
`ifdef RO_READ_STABLE_CHECK_EN
        retry_d  = retry_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CAP0;
`ifdef RO_READ_STABLE_CHECK_EN
                    retry_d = '0;
`endif
                end
            end
            S_CAP0, S_CAP1: begin
                if (take) begin
                    if (state_q == S_CAP0) begin
                        start0_d = a0_q;
                        start1_d = a1_q;
                        win_d    = WIN_LOAD;
                        state_d  = S_WAIT;
`ifdef RO_READ_STABLE_CHECK_EN
                        retry_d  = '0;
`endif
                    end else begin
                        // Modulo subtraction yields the right edge count across a counter wrap.
                        freq0_d = a0_q - start0_q;
                        freq1_d = a1_q - start1_q;
                        state_d = S_OUT;
`ifdef RO_READ_STABLE_CHECK_EN
                        err_d   = 1'b0;
`endif
                    end
                end
`ifdef RO_READ_STABLE_CHECK_EN
                else begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_LIMIT) begin
                        state_d = S_OUT;
                        err_d   = 1'b1;
                        freq0_d = '0;
                        freq1_d = '0;
                    end
                end
`endif
            end
            S_WAIT: begin
                // Loaded with winLen-1 and left on reading 0, so WAIT spans exactly winLen cycles.
                if (win_q == '0) begin
                    state_d = S_CAP1;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            S_OUT: begin
                if (freqReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign freqValid = (state_q == S_OUT);
    assign RO0Freq   = freq0_q;
    assign RO1Freq   = freq1_q;

endmodule

// File: tb/tb_ro_freq_reader.sv
// Self-checking bench for ro_freq_reader: directed scenarios plus randomized RO rates,
// judged against an edge-count model (edges in N cycles at one edge per p cycles).
module tb_ro_freq_reader;

    localparam int LEN   = 16;
    localparam int WIN   = 1024;
    localparam int RETRY = 7;
`ifdef RO_READ_STABLE_CHECK_EN
    // Each capture may be delayed by the stability check, widening the observed window.
    localparam int SLACK = 2;
`else
    localparam int SLACK = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           freqReady;
    logic [LEN-1:0] RO0Cnt;
    logic [LEN-1:0] RO1Cnt;
    logic           busy;
    logic [LEN-1:0] RO0Freq;
    logic [LEN-1:0] RO1Freq;
    logic           freqValid;
    logic           err;

    int n_tests = 0;
    int n_fail  = 0;
    int per0 = 0, per1 = 0, ph0 = 0, ph1 = 0;

    ro_freq_reader #(.length(LEN), .winLen(WIN), .maxRetry(RETRY)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .RO0Cnt    (RO0Cnt),
        .RO1Cnt    (RO1Cnt),
        .busy      (busy),
        .RO0Freq   (RO0Freq),
        .RO1Freq   (RO1Freq),
        .freqValid (freqValid),
        .freqReady (freqReady),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
        n_tests++;
        assert (int'(obs) >= lo && int'(obs) <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Edges counted by a counter advancing once per p cycles over WIN+1 (+/- SLACK) cycles.
    function automatic int edges_lo(input int p);
        return (p == 0) ? 0 : (WIN + 1 - SLACK) / p;
    endfunction

    function automatic int edges_hi(input int p);
        return (p == 0) ? 0 : (WIN + 1 + SLACK + p - 1) / p;
    endfunction

    // One clk cycle: step to the falling edge, then advance the emulated RO counters.
    task automatic tick();
        @(negedge clk);
        if (per0 > 0) begin
            ph0++;
            if (ph0 >= per0) begin
                ph0    = 0;
                RO0Cnt = RO0Cnt + 1'b1;
            end
        end
        if (per1 > 0) begin
            ph1++;
            if (ph1 >= per1) begin
                ph1    = 0;
                RO1Cnt = RO1Cnt + 1'b1;
            end
        end
    endtask

    task automatic configure(input int p0, input int p1, input logic [LEN-1:0] v0, input logic [LEN-1:0] v1);
        per0   = p0;
        per1   = p1;
        ph0    = 0;
        ph1    = 0;
        RO0Cnt = v0;
        RO1Cnt = v1;
        repeat (3) tick();
    endtask

    // Pulse start, optionally re-pulse it at cycle poke_at, and wait (bounded) for freqValid.
    task automatic measure(input int poke_at, output int lat, output bit seen);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!freqValid && lat < 3 * WIN) begin
            start = (lat == poke_at);
            tick();
            lat++;
        end
        start = 1'b0;
        seen  = freqValid;
    endtask

    task automatic release_result(input string tag);
        freqReady = 1'b1;
        tick();
        freqReady = 1'b0;
        check({tag, "_valid_drop"}, 32'(freqValid), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int             lat;
        bit             seen;
        int             bad;
        int             p0, p1;
        logic [LEN-1:0] f0, f1;
        logic           e;

        rst       = 1'b1;
        start     = 1'b0;
        freqReady = 1'b0;
        configure(0, 0, '0, '0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(freqValid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_f0", 32'(RO0Freq), 32'd0);
        check("rst_f1", 32'(RO1Freq), 32'd0);
        rst = 1'b0;
        tick();

        // Constant counts, with a stray start in the middle of the window.
        configure(0, 0, 16'd100, 16'd100);
        measure(100, lat, seen);
        check("const_seen", 32'(seen), 32'd1);
        check("const_latency", 32'(lat), 32'(WIN + 3));
        check("const_f0", 32'(RO0Freq), 32'd0);
        check("const_f1", 32'(RO1Freq), 32'd0);
        check("const_err", 32'(err), 32'd0);
        release_result("const");

        // RO0 one edge per 4 clk, RO1 one per 8 clk; then hold the result for 20 cycles.
        configure(4, 8, 16'($urandom), 16'($urandom));
        measure(-1, lat, seen);
        check("rate_seen", 32'(seen), 32'd1);
        check_range("rate_f0", 32'(RO0Freq), WIN / 4 - 1, WIN / 4 + 1);
        check_range("rate_f1", 32'(RO1Freq), WIN / 8 - 1, WIN / 8 + 1);
        check("rate_err", 32'(err), 32'd0);
        f0  = RO0Freq;
        f1  = RO1Freq;
        e   = err;
        bad = 0;
        repeat (20) begin
            tick();
            if (freqValid !== 1'b1 || busy !== 1'b1 || RO0Freq !== f0 || RO1Freq !== f1 || err !== e)
                bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        release_result("hold");
        check("after_xfer_f0", 32'(RO0Freq), 32'(f0));
        check("after_xfer_f1", 32'(RO1Freq), 32'(f1));

        // RO0 wraps through 0xFFFF during the window.
        configure(2, 0, 16'hFFF0, 16'($urandom));
        measure(-1, lat, seen);
        check("wrap_seen", 32'(seen), 32'd1);
        check_range("wrap_f0", 32'(RO0Freq), edges_lo(2), edges_hi(2));
        check("wrap_f1", 32'(RO1Freq), 32'd0);
        release_result("wrap");

        // RO0 changes on every clk cycle.
        configure(1, 0, 16'($urandom), 16'($urandom));
        measure(-1, lat, seen);
        check("fast_seen", 32'(seen), 32'd1);
`ifdef RO_READ_STABLE_CHECK_EN
        check("retry_latency", 32'(lat), 32'(RETRY + 1));
        check("retry_err", 32'(err), 32'd1);
        check("retry_f0", 32'(RO0Freq), 32'd0);
        check("retry_f1", 32'(RO1Freq), 32'd0);
`else
        check("fast_latency", 32'(lat), 32'(WIN + 3));
        check("fast_f0", 32'(RO0Freq), 32'(WIN + 1));
        check("fast_f1", 32'(RO1Freq), 32'd0);
        check("fast_err", 32'(err), 32'd0);
`endif
        release_result("fast");

        // Randomized rates and start values; the first run keeps freqReady high throughout.
        for (int run = 0; run < 3; run++) begin
            p0 = int'($urandom_range(4, 16));
            p1 = int'($urandom_range(4, 16));
            configure(p0, p1, 16'($urandom), 16'($urandom));
            freqReady = (run == 0);
            measure(-1, lat, seen);
            check($sformatf("rand%0d_seen", run), 32'(seen), 32'd1);
            check_range($sformatf("rand%0d_f0_p%0d", run, p0), 32'(RO0Freq), edges_lo(p0), edges_hi(p0));
            check_range($sformatf("rand%0d_f1_p%0d", run, p1), 32'(RO1Freq), edges_lo(p1), edges_hi(p1));
            check($sformatf("rand%0d_err", run), 32'(err), 32'd0);
            release_result($sformatf("rand%0d", run));
        end

        // Reset inside the window, together with start and freqReady, aborts silently.
        configure(4, 8, 16'($urandom), 16'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst       = 1'b1;
        start     = 1'b1;
        freqReady = 1'b1;
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        freqReady = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(freqValid), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_f0", 32'(RO0Freq), 32'd0);
        check("abort_f1", 32'(RO1Freq), 32'd0);
        bad = 0;
        repeat (WIN + 20) begin
            tick();
            if (freqValid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_stays_idle", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
